// File: rtl/control_unit.sv
// Main instruction decoder for the single-cycle mini RISC-V core.
// Decodes opcode/funct3/funct7 into registered datapath controls and flags unsupported encodings.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        is_branch,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic [2:0]  alu_ctrl,
  output logic        illegal
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_RTYPE,
    CLS_ITYPE
  } instr_class_e;

  logic [6:0]   w_opcode;
  logic [2:0]   w_funct3;
  logic [6:0]   w_funct7;
  instr_class_e w_class;
  alu_op_e      w_alu_op;

  logic w_is_branch;
  logic w_mem_to_reg;
  logic w_reg_write;
  logic w_mem_read;
  logic w_mem_write;
  logic w_alu_src;
  logic w_illegal;

  // rd, rs1, rs2 and immediate bits never influence the decode.
  logic w_unused_fields;

  assign w_opcode        = instr[6:0];
  assign w_funct3        = instr[14:12];
  assign w_funct7        = instr[31:25];
  assign w_unused_fields = ^{instr[24:15], instr[11:7]};

  // Classify the instruction and pick the ALU op; anything unmatched stays illegal/add.
  always_comb begin
    w_class  = CLS_ILLEGAL;
    w_alu_op = ALU_ADD;
    case (w_opcode)
      OP_LOAD: begin
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
          w_class = CLS_LOAD;
        end
      end
      OP_STORE: begin
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
          w_class = CLS_STORE;
        end
      end
      OP_BRANCH: begin
        if (w_funct3 == 3'b000) begin
          w_class  = CLS_BRANCH;
          w_alu_op = ALU_SUB;
        end
      end
      OP_RTYPE: begin
        case ({w_funct7, w_funct3})
          10'b0000000_000: begin w_class = CLS_RTYPE; w_alu_op = ALU_ADD; end
          10'b0100000_000: begin w_class = CLS_RTYPE; w_alu_op = ALU_SUB; end
          10'b0000000_111: begin w_class = CLS_RTYPE; w_alu_op = ALU_AND; end
          10'b0000000_110: begin w_class = CLS_RTYPE; w_alu_op = ALU_OR;  end
          10'b0000000_010: begin w_class = CLS_RTYPE; w_alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ITYPE: begin
        case (w_funct3)
          3'b000:  begin w_class = CLS_ITYPE; w_alu_op = ALU_ADD; end
          3'b111:  begin w_class = CLS_ITYPE; w_alu_op = ALU_AND; end
          3'b110:  begin w_class = CLS_ITYPE; w_alu_op = ALU_OR;  end
          3'b010:  begin w_class = CLS_ITYPE; w_alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    w_is_branch  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_illegal    = 1'b0;
    case (w_class)
      CLS_LOAD: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_alu_src    = 1'b1;
      end
      CLS_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      CLS_BRANCH: begin
        w_is_branch = 1'b1;
      end
      CLS_RTYPE: begin
        w_reg_write = 1'b1;
      end
      CLS_ITYPE: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_branch  <= 1'b0;
      mem_to_reg <= 1'b0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      alu_src    <= 1'b0;
      alu_ctrl   <= '0;
      illegal    <= 1'b0;
    end else begin
      is_branch  <= w_is_branch;
      mem_to_reg <= w_mem_to_reg;
      reg_write  <= w_reg_write;
      mem_read   <= w_mem_read;
      mem_write  <= w_mem_write;
      alu_src    <= w_alu_src;
      alu_ctrl   <= w_alu_op;
      illegal    <= w_illegal;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed control vectors, one-edge latency and hold checks.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        is_branch, mem_to_reg, reg_write, mem_read, mem_write, alu_src, illegal;
  logic [2:0]  alu_ctrl;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [9:0]  prev_exp;

  // Packed order: {is_branch, mem_to_reg, reg_write, mem_read, mem_write, alu_src, alu_ctrl, illegal}
  localparam logic [9:0] E_ZERO  = 10'b000000_000_0;
  localparam logic [9:0] E_BEQ   = 10'b100000_110_0;
  localparam logic [9:0] E_LOAD  = 10'b011101_010_0;
  localparam logic [9:0] E_STORE = 10'b000011_010_0;
  localparam logic [9:0] E_ADD   = 10'b001000_010_0;
  localparam logic [9:0] E_SUB   = 10'b001000_110_0;
  localparam logic [9:0] E_AND   = 10'b001000_000_0;
  localparam logic [9:0] E_OR    = 10'b001000_001_0;
  localparam logic [9:0] E_SLT   = 10'b001000_111_0;
  localparam logic [9:0] E_ADDI  = 10'b001001_010_0;
  localparam logic [9:0] E_ANDI  = 10'b001001_000_0;
  localparam logic [9:0] E_ORI   = 10'b001001_001_0;
  localparam logic [9:0] E_SLTI  = 10'b001001_111_0;
  localparam logic [9:0] E_ILL   = 10'b000000_010_1;

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .is_branch  (is_branch),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {is_branch, mem_to_reg, reg_write, mem_read, mem_write, alu_src, alu_ctrl, illegal};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive at negedge, confirm outputs still hold the previous decode, then check one edge later.
  task automatic step(input string tag, input logic rst, input logic [31:0] in, input logic [9:0] exp);
    @(negedge clk);
    rst_n = rst;
    instr = in;
    #1 check({tag, "/hold"}, prev_exp);
    @(posedge clk);
    #1 check(tag, exp);
    prev_exp = exp;
  endtask

  initial begin
    rst_n = 1'b0;
    instr = 32'h02208463;
    @(posedge clk);
    #1 check("reset0", E_ZERO);
    prev_exp = E_ZERO;

    step("reset1",      1'b0, 32'h02208463, E_ZERO);
    step("beq",         1'b1, 32'h02208463, E_BEQ);
    step("ld",          1'b1, 32'h02813083, E_LOAD);
    step("sd",          1'b1, 32'h02113423, E_STORE);
    step("lw",          1'b1, 32'h00002003, E_LOAD);
    step("sw",          1'b1, 32'h00002023, E_STORE);
    step("add",         1'b1, 32'h002081B3, E_ADD);
    step("sub",         1'b1, 32'h402081B3, E_SUB);
    step("and",         1'b1, 32'h0020F1B3, E_AND);
    step("or",          1'b1, 32'h0020E1B3, E_OR);
    step("slt",         1'b1, 32'h0020A1B3, E_SLT);
    step("addi",        1'b1, 32'h02808193, E_ADDI);
    step("addi_f7",     1'b1, 32'h40008193, E_ADDI);
    step("andi",        1'b1, 32'h0FF0F193, E_ANDI);
    step("ori",         1'b1, 32'h0FF0E193, E_ORI);
    step("slti",        1'b1, 32'h0FF0A193, E_SLTI);
    step("opc7f",       1'b1, 32'h0000007F, E_ILL);
    step("bne",         1'b1, 32'h00209463, E_ILL);
    step("beq_fields",  1'b1, 32'hFE0F8EE3, E_BEQ);
    step("lb",          1'b1, 32'h00000003, E_ILL);
    step("sub_f3_and",  1'b1, 32'h4020F1B3, E_ILL);
    step("mul",         1'b1, 32'h022081B3, E_ILL);
    step("slli",        1'b1, 32'h00109193, E_ILL);
    step("zero_word",   1'b1, 32'h00000000, E_ILL);
    step("ld_b2b",      1'b1, 32'h02813083, E_LOAD);
    step("mid_reset",   1'b0, 32'h02813083, E_ZERO);
    step("x_reset",     1'b0, 32'hxxxxxxxx, E_ZERO);
    step("after_reset", 1'b1, 32'h002081B3, E_ADD);
    step("sd_b2b",      1'b1, 32'h02113423, E_STORE);
    step("ill_b2b",     1'b1, 32'h0000007F, E_ILL);
    step("beq_b2b",     1'b1, 32'h02208463, E_BEQ);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
